// File: rtl/atm_pkg.sv
// Shared types for the ATM session controller: FSM state encoding and
// the error codes reported alongside the issue pulse.
package atm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_CHK = 2'd1,
    WAIT_AMT = 2'd2,
    LOCK     = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_PIN  = 2'd1;
  localparam logic [1:0] ERR_AMT  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

endpackage

// File: rtl/atm_timeout_ctr.sv
// Inactivity counter for the session wait states. Counts enabled cycles
// since the last clear and raises expire during the TIMEOUT-th idle cycle,
// so the owning FSM acts on it at the edge that closes that cycle.
module atm_timeout_ctr #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign expire = en && (cnt == CW'(TIMEOUT - 1));

  // Idle-cycle counter; holds once expired until the FSM leaves the wait state.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM card-session controller: PIN entry/confirm, withdrawal against a
// running balance and per-withdrawal limit, retry lockout with operator
// unlock. Define ATM_TIMEOUT_EN to compile in the inactivity timeout for
// the two wait states; without it those states wait indefinitely.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int PIN_W     = 14,
  parameter int AMT_W     = 15,
  parameter int BAL_W     = 17,
  parameter int BAL_INIT  = 50000,
  parameter int WD_LIMIT  = 20000,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pin_ent,
  input  logic [PIN_W-1:0]                 pin,
  input  logic                             pin_chk,
  input  logic [PIN_W-1:0]                 pin_cnfm,
  input  logic                             amt_ent,
  input  logic [AMT_W-1:0]                 amt,
  input  logic                             unlock,
  output logic                             disp,
  output logic                             issue,
  output logic [1:0]                       err_code,
  output logic                             locked,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries,
  output logic [BAL_W-1:0]                 balance
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [BAL_W-1:0] LIMIT    = BAL_W'(WD_LIMIT);
  localparam logic [BAL_W-1:0] BAL_RST  = BAL_W'(BAL_INIT);
  localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);

  state_t           state;
  logic [PIN_W-1:0] pin_q;
  logic [BAL_W-1:0] amt_ext;
  logic             amt_ok;
  logic [TRY_W-1:0] tries_inc;
  logic             expire;

  assign amt_ext   = BAL_W'(amt);
  assign amt_ok    = (amt_ext != '0) && (amt_ext <= LIMIT) && (amt_ext <= balance);
  assign tries_inc = tries + TRY_W'(1);

`ifdef ATM_TIMEOUT_EN
  logic tmo_en;
  logic tmo_clr;

  // The counter runs only in the wait states and restarts whenever a strobe
  // is accepted, so each wait state is entered with a fresh count.
  assign tmo_en  = (state == WAIT_CHK) || (state == WAIT_AMT);
  assign tmo_clr = !tmo_en
                || ((state == WAIT_CHK) && pin_chk)
                || ((state == WAIT_AMT) && amt_ent);

  atm_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  // Session FSM with registered one-cycle disp/issue pulses; strobes take
  // priority over a coincident timeout expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pin_q    <= '0;
      disp     <= 1'b0;
      issue    <= 1'b0;
      err_code <= ERR_NONE;
      locked   <= 1'b0;
      tries    <= '0;
      balance  <= BAL_RST;
    end else begin
      disp     <= 1'b0;
      issue    <= 1'b0;
      err_code <= ERR_NONE;
      case (state)
        IDLE: begin
          if (pin_ent) begin
            pin_q <= pin;
            state <= WAIT_CHK;
          end
        end
        WAIT_CHK: begin
          if (pin_chk) begin
            if (pin_cnfm == pin_q) begin
              tries <= '0;
              state <= WAIT_AMT;
            end else begin
              tries    <= tries_inc;
              issue    <= 1'b1;
              err_code <= ERR_PIN;
              if (tries_inc == TRY_MAX) begin
                locked <= 1'b1;
                state  <= LOCK;
              end else begin
                state <= IDLE;
              end
            end
          end else if (expire) begin
            issue    <= 1'b1;
            err_code <= ERR_TMO;
            state    <= IDLE;
          end
        end
        WAIT_AMT: begin
          if (amt_ent) begin
            if (amt_ok) begin
              balance <= balance - amt_ext;
              disp    <= 1'b1;
            end else begin
              issue    <= 1'b1;
              err_code <= ERR_AMT;
            end
            state <= IDLE;
          end else if (expire) begin
            issue    <= 1'b1;
            err_code <= ERR_TMO;
            state    <= IDLE;
          end
        end
        LOCK: begin
          if (unlock) begin
            tries  <= '0;
            locked <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/atm_session_ctrl.md
# atm_session_ctrl

Parametrised successor to the single-shot ATM controller. Runs a full card session: PIN entry and confirm, withdrawal request, dispense or issue report. Adds a retry counter with lockout, a running account balance, a per-withdrawal limit, error codes and an optional inactivity timeout. Sits between the keypad/host front-end and the cash-dispense actuator.

## Interface
- `PIN_W`, default 14: PIN width.
- `AMT_W`, default 15: amount width.
- `BAL_W`, default 17: balance width; must be ≥ `AMT_W`.
- `BAL_INIT`, default 50000: balance after reset.
- `WD_LIMIT`, default 20000: maximum single withdrawal.
- `MAX_TRIES`, default 3: consecutive PIN mismatches that cause lockout.
- `TIMEOUT`, default 8: idle cycles allowed in the wait states; must be ≥ 2.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `pin_ent`  in  1  strobe; `pin` is valid.
- `pin`  in  `PIN_W`  entered PIN.
- `pin_chk`  in  1  strobe; `pin_cnfm` is valid.
- `pin_cnfm`  in  `PIN_W`  confirmation PIN.
- `amt_ent`  in  1  strobe; `amt` is valid.
- `amt`  in  `AMT_W`  requested amount.
- `unlock`  in  1  operator release from lockout.
- `disp`  out  1  one-cycle pulse; dispense `amt`.
- `issue`  out  1  one-cycle pulse; the session is aborted.
- `err_code`  out  2  valid while `issue`=1: 0 none, 1 PIN mismatch, 2 invalid amount, 3 timeout.
- `locked`  out  1  level; the session controller is locked out.
- `tries`  out  `$clog2(MAX_TRIES+1)`  current consecutive mismatch count.
- `balance`  out  `BAL_W`  current balance.

## Operation
- States: IDLE, WAIT_CHK, WAIT_AMT, LOCK.
- IDLE, `pin_ent`=1: register `pin` into `pin_q`; go to WAIT_CHK.
- WAIT_CHK, `pin_chk`=1, `pin_cnfm`==`pin_q`: clear `tries`; go to WAIT_AMT.
- WAIT_CHK, `pin_chk`=1, mismatch: increment `tries`; pulse `issue` with `err_code` 1.
  - If the new `tries`==`MAX_TRIES`, go to LOCK.
  - Otherwise go to IDLE.
- WAIT_AMT, `amt_ent`=1, invalid amount: pulse `issue` with `err_code` 2; `balance` is unchanged; go to IDLE.
  - An amount is invalid if `amt`==0, `amt`>`WD_LIMIT`, or `amt`>`balance`.
  - Compare with `amt` zero-extended to `BAL_W`.
- WAIT_AMT, `amt_ent`=1, valid amount: `balance` ← `balance`−`amt`; pulse `disp`; go to IDLE.
- LOCK: `locked`=1. All strobes are ignored.
  - `unlock`=1: clear `tries`; go to IDLE.
- Strobes that do not belong to the current state are ignored; `pin_ent` in WAIT_CHK does not recapture.
- `unlock` outside LOCK is ignored.
- `disp` and `issue` are never high together.
- `balance` never underflows; the amount check guarantees it.

## Timing
- Reset values:
  - state IDLE.
  - `disp`, `issue`, `err_code`, `locked`, `tries`, `pin_q` = 0.
  - `balance` = `BAL_INIT`.
- Latency:
  - An accepted strobe at edge N produces `disp`/`issue`, the `balance` update and the state change, all visible after edge N.
  - `disp` and `issue` are registered, one cycle wide.
- `locked` rises in the same cycle as the third `issue`. It falls the cycle after `unlock` is sampled.
- `rst` asserted mid-session (any state, including LOCK) aborts the session without any `issue` pulse and restores the reset values.
- Timeout: the counter clears on entry to WAIT_CHK and WAIT_AMT.
  - If it reaches `TIMEOUT` cycles with no accepted strobe: pulse `issue` with `err_code` 3 and go to IDLE.
  - A timeout does not increment `tries`.
  - If an accepted strobe arrives in the same cycle as expiry, the strobe wins.

## Configuration
- `ATM_TIMEOUT_EN` defined: the inactivity timeout above is compiled in.
- `ATM_TIMEOUT_EN` undefined: no counter exists; WAIT_CHK and WAIT_AMT wait indefinitely; `err_code` 3 is never produced.

## Structure
- Shared package `atm_pkg` holds:
  - the state enum.
  - the `err_code` constants `ERR_NONE`, `ERR_PIN`, `ERR_AMT`, `ERR_TMO`.
- One sub-module, `atm_timeout_ctr`, instantiated only under `ATM_TIMEOUT_EN`.
  - Inputs: clear and enable.
  - Output: an expiry pulse.

## Test plan
All scenarios use the default parameters.
- Valid withdrawal: pin 8434, cnfm 8434, amt 15000 → `disp` pulse one cycle after `amt_ent`; `balance` 35000; `issue` stays 0.
- Lockout: three sessions of pin 8434 / cnfm 1234 → `issue` with `err_code` 1 each time; `tries` counts 1, 2, 3; `locked`=1 after the third.
  - A following `pin_ent` is ignored.
  - `unlock` → IDLE, `tries` 0, `locked` 0.
- Over limit: pin 5587 / cnfm 5587, amt 20001 → `issue` with `err_code` 2; `balance` stays 50000.
- Balance drain: valid sessions with amt 20000, 20000, then 15000.
  - The first two give `disp`; `balance` goes 30000, then 10000.
  - The third gives `issue` with `err_code` 2; `balance` stays 10000.
- Timeout (`ATM_TIMEOUT_EN` defined): `pin_ent`, then no strobe for 8 cycles → `issue` with `err_code` 3; state IDLE; `tries` unchanged.
- Reset mid-session: assert `rst` in WAIT_AMT after one 15000 withdrawal → state IDLE; `balance` 50000; all outputs 0; no `issue` pulse.
